// File: rtl/nonlin_layer_sequencer.sv
// nonlin_layer_sequencer: drives one NONLINEAR_LAYER evaluation per request
//   (clear layer, stream ROM terms plus a 1.0 bias, wait out the MACC pipe, capture result).
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i, abort_i       request an evaluation / cancel one in progress
//   sample_base_i          ROM address of term 0, latched when start_i is accepted
//   busy_o, done_o         evaluation in flight / one-cycle result-valid pulse
//   rom_addr_o, rom_data_i input-ROM port (read latency 1 cycle)
//   layer_rst_o, acc_en_o, layer_in_o, layer_result_i   layer interface
//   result_o, result_exc_o captured result and its inf/NaN flag
module nonlin_layer_sequencer #(
   parameter int BIT_WIDTH    = 32,
   parameter int EXTRA_BITS   = 2,
   parameter int NUM_UNKNOWNS = 2,
   parameter int MAC_LATENCY  = 3,
   parameter int CLR_CYCLES   = 2,
   parameter int ADDR_WIDTH   = 4
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             start_i,
   input  logic                             abort_i,
   input  logic [ADDR_WIDTH-1:0]            sample_base_i,
   output logic                             busy_o,
   output logic                             done_o,
   output logic [ADDR_WIDTH-1:0]            rom_addr_o,
   input  logic [BIT_WIDTH+EXTRA_BITS-1:0]  rom_data_i,
   output logic                             layer_rst_o,
   output logic                             acc_en_o,
   output logic [BIT_WIDTH+EXTRA_BITS-1:0]  layer_in_o,
   input  logic [BIT_WIDTH+EXTRA_BITS-1:0]  layer_result_i,
   output logic [BIT_WIDTH+EXTRA_BITS-1:0]  result_o,
   output logic                             result_exc_o
);
   localparam int DW    = BIT_WIDTH + EXTRA_BITS;
   localparam int TERMS = NUM_UNKNOWNS + 1;
   localparam int CW    = $clog2(CLR_CYCLES + TERMS + MAC_LATENCY + 1);
   localparam logic [DW-1:0] BIAS = {EXTRA_BITS'(1), BIT_WIDTH'(32'h3F80_0000)};

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_CAPTURE, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_d;
   logic                  busy_q, busy_d, done_q, done_d, lrst_q, lrst_d, acc_en_q, acc_en_d;
   logic                  feed_rom_q, feed_rom_d;
   logic [DW-1:0]         lin_q, lin_d, result_q, result_d;
   logic                  exc_q, exc_d;
   logic                  idle_or_done, abort_ok, cnt_last;

   always_comb begin
      idle_or_done = state_q == S_IDLE || state_q == S_DONE;
      abort_ok     = abort_i && !idle_or_done;
      cnt_last     = cnt_q == (state_q == S_CLEAR ? CW'(CLR_CYCLES-1) :
                               state_q == S_FEED  ? CW'(TERMS-1) : CW'(MAC_LATENCY-1));
      state_d      = state_q;
      unique case (state_q)
         S_IDLE, S_DONE: state_d = start_i ? S_CLEAR : S_IDLE;
         S_CLEAR:        state_d = cnt_last ? S_FEED : S_CLEAR;
         S_FEED:         state_d = cnt_last ? S_DRAIN : S_FEED;
         S_DRAIN:        state_d = cnt_last ? S_CAPTURE : S_DRAIN;
         S_CAPTURE:      state_d = S_DONE;
         default:        state_d = S_IDLE;
      endcase
      if (abort_ok) state_d = S_IDLE;
      cnt_d      = (state_d == state_q && state_q != S_IDLE) ? cnt_q + CW'(1) : '0;
      base_d     = (start_i && idle_or_done) ? sample_base_i : base_q;
      // Present the base address in the last CLEAR cycle so term 0 arrives on the first FEED cycle.
      addr_d     = (state_d == S_CLEAR && cnt_d == CW'(CLR_CYCLES-1)) ? base_d :
                   state_d == S_FEED ? addr_q + ADDR_WIDTH'(1) : addr_q;
      busy_d     = state_d == S_CLEAR || state_d == S_FEED || state_d == S_DRAIN || state_d == S_CAPTURE;
      done_d     = state_d == S_DONE;
      lrst_d     = state_d == S_CLEAR || abort_ok;
      acc_en_d   = state_d == S_FEED;
      feed_rom_d = state_d == S_FEED && cnt_d < CW'(NUM_UNKNOWNS);
      lin_d      = (state_d == S_FEED && cnt_d == CW'(NUM_UNKNOWNS)) ? BIAS : '0;
      result_d   = (state_q == S_CAPTURE && !abort_ok) ? layer_result_i : result_q;
      exc_d      = (state_q == S_CAPTURE && !abort_ok) ? layer_result_i[DW-1] : exc_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         base_q     <= '0;
         addr_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         lrst_q     <= 1'b1;
         acc_en_q   <= 1'b0;
         feed_rom_q <= 1'b0;
         lin_q      <= '0;
         result_q   <= '0;
         exc_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         base_q     <= base_d;
         addr_q     <= addr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         lrst_q     <= lrst_d;
         acc_en_q   <= acc_en_d;
         feed_rom_q <= feed_rom_d;
         lin_q      <= lin_d;
         result_q   <= result_d;
         exc_q      <= exc_d;
      end
   end

   // ROM data is already registered inside the ROM, so data terms pass straight through.
   assign layer_in_o   = feed_rom_q ? rom_data_i : lin_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign rom_addr_o   = addr_q;
   assign layer_rst_o  = lrst_q;
   assign acc_en_o     = acc_en_q;
   assign result_o     = result_q;
   assign result_exc_o = exc_q;
endmodule

// File: tb/tb_nonlin_layer_sequencer.sv
// tb_nonlin_layer_sequencer: directed bench with ROM and accumulating layer stub
module tb_nonlin_layer_sequencer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0, abort = 1'b0;
   logic [3:0]  base = '0;
   logic        busy, done, layer_rst, acc_en, result_exc;
   logic [3:0]  rom_addr;
   logic [33:0] rom_data, layer_in, layer_result, result;
   logic [33:0] rom [16];
   logic        force_nan = 1'b0;
   logic        start2 = 1'b0, abort2 = 1'b0;
   logic [1:0]  base2 = '0;
   logic        busy2, done2, layer_rst2, acc_en2, result_exc2;
   logic [1:0]  rom_addr2;
   logic [33:0] rom2_data, layer_in2, result2;
   logic [33:0] rom2 [4];
   logic [33:0] zero34 = '0;
   int          checks = 0, errors = 0;
   real         acc = 0.0;
   logic [33:0] d0 = '0, d1 = '0;

   localparam logic [33:0] F1   = {2'b01, 32'h3F80_0000};
   localparam logic [33:0] F2   = {2'b01, 32'h4000_0000};
   localparam logic [33:0] F05  = {2'b01, 32'h3F00_0000};
   localparam logic [33:0] F025 = {2'b01, 32'h3E80_0000};
   localparam logic [33:0] F3   = {2'b01, 32'h4040_0000};
   localparam logic [33:0] F5   = {2'b01, 32'h40A0_0000};
   localparam logic [33:0] F4   = {2'b01, 32'h4080_0000};
   localparam logic [33:0] F175 = {2'b01, 32'h3FE0_0000};
   localparam logic [33:0] QNAN = {2'b11, 32'h7FC0_0000};

   always #5 clk = ~clk;

   nonlin_layer_sequencer u_dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .sample_base_i(base),
      .busy_o(busy), .done_o(done), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
      .layer_rst_o(layer_rst), .acc_en_o(acc_en), .layer_in_o(layer_in),
      .layer_result_i(layer_result), .result_o(result), .result_exc_o(result_exc)
   );

   nonlin_layer_sequencer #(.ADDR_WIDTH(2)) u_dut2 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .abort_i(abort2), .sample_base_i(base2),
      .busy_o(busy2), .done_o(done2), .rom_addr_o(rom_addr2), .rom_data_i(rom2_data),
      .layer_rst_o(layer_rst2), .acc_en_o(acc_en2), .layer_in_o(layer_in2),
      .layer_result_i(zero34), .result_o(result2), .result_exc_o(result_exc2)
   );

   function automatic real dec(input logic [33:0] v);
      real f;
      int  e;
      if (v[33:32] != 2'b01) return 0.0;
      f = 1.0 + real'(v[22:0]) / 8388608.0;
      e = int'(v[30:23]) - 127;
      while (e > 0) begin f = f * 2.0; e--; end
      while (e < 0) begin f = f / 2.0; e++; end
      return v[31] ? -f : f;
   endfunction

   function automatic logic [33:0] enc(input real r);
      real  f;
      int   e, mi;
      logic s;
      if (r == 0.0) return '0;
      s = r < 0.0;
      f = s ? -r : r;
      e = 127;
      while (f >= 2.0) begin f = f / 2.0; e++; end
      while (f < 1.0) begin f = f * 2.0; e--; end
      mi = $rtoi((f - 1.0) * 8388608.0);
      return {2'b01, s, e[7:0], mi[22:0]};
   endfunction

   always @(posedge clk) begin
      rom_data  <= rom[rom_addr];
      rom2_data <= rom2[rom_addr2];
      acc       <= layer_rst ? 0.0 : acc_en ? acc + dec(layer_in) : acc;
      d0        <= enc(acc);
      d1        <= d0;
   end
   assign layer_result = force_nan ? QNAN : d1;

   task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int dones, accs;
      logic d10, d20;
      logic [33:0] r10;
      foreach (rom[i]) rom[i] = '0;
      rom[0] = F1; rom[1] = F2; rom[2] = F05; rom[3] = F025;
      rom2[0] = F5; rom2[1] = '0; rom2[2] = '0; rom2[3] = F3;
      #1 rst_n = 1'b0;
      step(2);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_layer_rst", layer_rst, 1);
      chk("rst_acc_en", acc_en, 0);
      chk("rst_layer_in", layer_in, 0);
      chk("rst_result", result, 0);
      chk("rst_result_exc", result_exc, 0);
      rst_n = 1'b1;
      step(1);
      chk("idle_layer_rst", layer_rst, 0);

      // single evaluation, base 0: 1.0 + 2.0 + bias
      start = 1'b1; base = 4'd0;
      step(1); start = 1'b0;
      chk("t1_c1_busy", busy, 1);
      chk("t1_c1_layer_rst", layer_rst, 1);
      step(1); chk("t1_c2_prefetch", rom_addr, 0);
      step(1);
      chk("t1_c3_acc_en", acc_en, 1);
      chk("t1_c3_layer_rst", layer_rst, 0);
      chk("t1_c3_layer_in", layer_in, F1);
      step(1); chk("t1_c4_layer_in", layer_in, F2);
      step(1); chk("t1_c5_bias", layer_in, F1);
      step(1);
      chk("t1_c6_acc_en", acc_en, 0);
      chk("t1_c6_layer_in", layer_in, 0);
      step(3); chk("t1_c9_done", done, 0);
      step(1);
      chk("t1_c10_done", done, 1);
      chk("t1_c10_busy", busy, 0);
      chk("t1_result", result, F4);
      chk("t1_result_exc", result_exc, 0);
      step(1); chk("t1_c11_done", done, 0);

      // abort in second FEED cycle
      start = 1'b1; base = 4'd2;
      step(1); start = 1'b0;
      step(3); abort = 1'b1;
      step(1); abort = 1'b0;
      chk("ab_busy", busy, 0);
      chk("ab_layer_rst", layer_rst, 1);
      chk("ab_acc_en", acc_en, 0);
      step(1); chk("ab_layer_rst_end", layer_rst, 0);
      dones = 0;
      for (int c = 0; c < 12; c++) begin step(1); dones += int'(done); end
      chk("ab_no_done", dones, 0);
      chk("ab_result_kept", result, F4);

      // back-to-back: START held, base switched to 2 after the first accept
      start = 1'b1; base = 4'd0;
      dones = 0; d10 = 0; d20 = 0; r10 = '0;
      for (int c = 1; c <= 20; c++) begin
         step(1);
         if (c == 1) base = 4'd2;
         dones += int'(done);
         if (c == 10) begin d10 = done; r10 = result; end
         if (c == 11) chk("b2b_no_bubble", busy, 1);
         if (c == 20) begin d20 = done; start = 1'b0; end
      end
      chk("b2b_done10", d10, 1);
      chk("b2b_result10", r10, F4);
      chk("b2b_done20", d20, 1);
      chk("b2b_result20", result, F175);
      chk("b2b_done_count", dones, 2);

      // async reset during DRAIN, then a clean evaluation
      start = 1'b1; base = 4'd0;
      step(1); start = 1'b0;
      step(6);
      rst_n = 1'b0;
      #1;
      chk("ar_busy", busy, 0);
      chk("ar_acc_en", acc_en, 0);
      chk("ar_layer_rst", layer_rst, 1);
      chk("ar_result", result, 0);
      chk("ar_rom_addr", rom_addr, 0);
      step(1); rst_n = 1'b1;
      step(1); start = 1'b1; base = 4'd2;
      step(1); start = 1'b0;
      step(9);
      chk("ar_rerun_done", done, 1);
      chk("ar_rerun_result", result, F175);

      // NaN result with ignored START pulses while busy
      force_nan = 1'b1;
      start = 1'b1; base = 4'd0;
      dones = 0; d10 = 0; r10 = '0;
      for (int c = 1; c <= 25; c++) begin
         step(1);
         start = (c == 5 || c == 8);
         dones += int'(done);
         if (c == 10) begin d10 = done; r10 = {33'd0, result_exc}; end
      end
      chk("nan_done10", d10, 1);
      chk("nan_exc", r10, 1);
      chk("nan_result", result, QNAN);
      chk("nan_done_count", dones, 1);
      force_nan = 1'b0;

      // 2-bit address wrap: base 3 feeds ROM[3] then ROM[0]
      start2 = 1'b1; base2 = 2'd3;
      accs = 0;
      for (int c = 1; c <= 12; c++) begin
         step(1);
         start2 = 1'b0;
         accs += int'(acc_en2);
         if (c == 2) chk("w_c2_addr", rom_addr2, 3);
         if (c == 3) begin chk("w_c3_addr", rom_addr2, 0); chk("w_c3_in", layer_in2, F3); end
         if (c == 4) chk("w_c4_in", layer_in2, F5);
         if (c == 5) chk("w_c5_bias", layer_in2, F1);
      end
      chk("w_acc_en_cycles", accs, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
